// File: rtl/board_move_ctrl_pkg.sv
// Shared chess definitions: piece encoding, start position and square index width.
// The video generator imports this package to decode the board read port.
package chess_pkg;

  localparam int SQ_W = 6;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef enum logic [2:0] {
    PT_EMPTY  = 3'd0,
    PT_PAWN   = 3'd1,
    PT_KNIGHT = 3'd2,
    PT_BISHOP = 3'd3,
    PT_ROOK   = 3'd4,
    PT_QUEEN  = 3'd5,
    PT_KING   = 3'd6
  } piece_type_e;

  typedef logic [3:0] piece_t;
  typedef piece_t board_t [64];

  function automatic piece_t piece_code(input logic color, input piece_type_e ptype);
    return {color, ptype};
  endfunction

  // Index 0 is a1 (white queen-side rook); ranks ascend in steps of eight.
  localparam board_t START_BOARD = '{
    4'h4, 4'h2, 4'h3, 4'h5, 4'h6, 4'h3, 4'h2, 4'h4,
    4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
    4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9,
    4'hC, 4'hA, 4'hB, 4'hD, 4'hE, 4'hB, 4'hA, 4'hC
  };

endpackage

// File: rtl/board_move_ctrl_if.sv
// Move command handshake between the game/input logic (master) and the board controller (slave).
interface board_move_ctrl_if;
  import chess_pkg::*;

  logic            mv_valid;
  logic            mv_ready;
  logic [SQ_W-1:0] mv_src;
  logic [SQ_W-1:0] mv_dst;
  logic [2:0]      mv_promo;
  logic            mv_done;
  logic            mv_err;
  piece_t          mv_capt;

  modport master (
    output mv_valid, mv_src, mv_dst, mv_promo,
    input  mv_ready, mv_done, mv_err, mv_capt
  );

  modport slave (
    input  mv_valid, mv_src, mv_dst, mv_promo,
    output mv_ready, mv_done, mv_err, mv_capt
  );

endinterface

// File: rtl/board_move_ctrl.sv
// Live chess board with a move-command FSM (basic legality, promotion, turn, move count)
// and a registered square read port for the video pixel path.
module board_move_ctrl
  import chess_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  board_move_ctrl_if.slave mv,
  output logic             turn,
  output logic [CNT_W-1:0] mv_count,
  input  logic [SQ_W-1:0]  sq_rd_addr,
  output piece_t           sq_rd_data
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, RESP} state_e;

  state_e           state_q;
  board_t           board_q;
  logic [SQ_W-1:0]  src_q;
  logic [SQ_W-1:0]  dst_q;
  logic [2:0]       promo_q;
  piece_t           sp_q;
  piece_t           dp_q;
  logic             pendErr_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;
  piece_t           capt_q;
  logic             turn_q;
  logic [CNT_W-1:0] cnt_q;
  piece_t           rd_q;

  piece_t srcPiece;
  piece_t dstPiece;
  piece_t wrPiece;
  logic   chkErr;
  logic   promote;

  // Legality is judged directly from the live board in CHECK; promotion from the pieces latched there.
  always_comb begin
    srcPiece = board_q[src_q];
    dstPiece = board_q[dst_q];
    chkErr   = (srcPiece[2:0] == PT_EMPTY) || (src_q == dst_q) || (srcPiece[3] != turn_q) ||
               ((dstPiece != 4'h0) && (dstPiece[3] == srcPiece[3]));
    promote  = (sp_q[2:0] == PT_PAWN) &&
               (((sp_q[3] == WHITE) && (dst_q[5:3] == 3'd7)) ||
                ((sp_q[3] == BLACK) && (dst_q[5:3] == 3'd0)));
    wrPiece  = sp_q;
    if (promote) begin
      if ((promo_q >= 3'd2) && (promo_q <= 3'd5)) begin
        wrPiece = piece_code(sp_q[3], piece_type_e'(promo_q));
      end else begin
        wrPiece = piece_code(sp_q[3], PT_QUEEN);
      end
    end
  end

  // new_game outranks everything, aborting a move in flight without a completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q   <= START_BOARD;
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      promo_q   <= '0;
      sp_q      <= '0;
      dp_q      <= '0;
      pendErr_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      capt_q    <= '0;
      turn_q    <= WHITE;
      cnt_q     <= '0;
    end else if (new_game) begin
      board_q <= START_BOARD;
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      turn_q  <= WHITE;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mv.mv_valid) begin
            src_q   <= mv.mv_src;
            dst_q   <= mv.mv_dst;
            promo_q <= mv.mv_promo;
            ready_q <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          sp_q      <= srcPiece;
          dp_q      <= dstPiece;
          pendErr_q <= chkErr;
          state_q   <= chkErr ? RESP : WRITE;
        end
        WRITE: begin
          board_q[dst_q] <= wrPiece;
          board_q[src_q] <= 4'h0;
          turn_q         <= ~turn_q;
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          state_q <= RESP;
        end
        RESP: begin
          done_q  <= 1'b1;
          err_q   <= pendErr_q;
          capt_q  <= pendErr_q ? 4'h0 : dp_q;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= board_q[sq_rd_addr];
    end
  end

  assign mv.mv_ready = ready_q;
  assign mv.mv_done  = done_q;
  assign mv.mv_err   = err_q;
  assign mv.mv_capt  = capt_q;
  assign turn        = turn_q;
  assign mv_count    = cnt_q;
  assign sq_rd_data  = rd_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Self-checking bench for board_move_ctrl: scripted and random moves against a square-list chess model.
module tb_board_move_ctrl;

  localparam int CNT_W   = 10;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  typedef struct {
    int src;
    int dst;
    int promo;
  } move_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             new_game;
  logic             turn;
  logic [CNT_W-1:0] mv_count;
  logic [5:0]       sq_rd_addr;
  logic [3:0]       sq_rd_data;

  int vectors     = 0;
  int miscompares = 0;

  int         refBoard [64];
  bit         refTurn;
  int         refCount;
  logic [3:0] dutBoard [64];

  board_move_ctrl_if mvIf ();

  board_move_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .mv         (mvIf),
    .turn       (turn),
    .mv_count   (mv_count),
    .sq_rd_addr (sq_rd_addr),
    .sq_rd_data (sq_rd_data)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model of the board: white back rank R N B Q K B N R, pawns on ranks 1 and 6, black mirrors white with the colour bit set.
  task automatic modelReset();
    int backRank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int sq = 0; sq < 64; sq++) refBoard[sq] = 0;
    for (int f = 0; f < 8; f++) begin
      refBoard[f]      = backRank[f];
      refBoard[8 + f]  = 1;
      refBoard[48 + f] = 8 + 1;
      refBoard[56 + f] = 8 + backRank[f];
    end
    refTurn  = 1'b0;
    refCount = 0;
  endtask

  task automatic modelMove(input int src, input int dst, input int promo,
                           output bit expErr, output logic [3:0] expCapt);
    int sp      = refBoard[src];
    int dp      = refBoard[dst];
    bit spBlack = (sp >= 8);
    int spType  = sp % 8;
    int newPiece;
    expErr  = (spType == 0) || (src == dst) || (spBlack != refTurn) ||
              ((dp != 0) && ((dp >= 8) == spBlack));
    expCapt = 4'h0;
    if (!expErr) begin
      newPiece = sp;
      if (spType == 1 && ((!spBlack && dst / 8 == 7) || (spBlack && dst / 8 == 0))) begin
        newPiece = (spBlack ? 8 : 0) + ((promo >= 2 && promo <= 5) ? promo : 5);
      end
      refBoard[dst] = newPiece;
      refBoard[src] = 0;
      refTurn       = !refTurn;
      if (refCount < MAX_CNT) refCount++;
      expCapt = 4'(dp);
    end
  endtask

  // Issue one move and observe its response; lat counts clock edges from the accepting edge to mv_done (-1 if it never comes).
  task automatic applyStimulus(input int src, input int dst, input int promo, input bit holdValid,
                               output int lat, output logic errO, output logic [3:0] captO,
                               output bit pulseOk, output bit readyOk);
    int waitCnt = 0;
    int srcV    = src;
    int dstV    = dst;
    int promoV  = promo;
    lat     = -1;
    errO    = 1'bx;
    captO   = 4'hx;
    readyOk = 1'b1;
    while (mvIf.mv_ready !== 1'b1 && waitCnt < 20) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    mvIf.mv_src   = srcV[5:0];
    mvIf.mv_dst   = dstV[5:0];
    mvIf.mv_promo = promoV[2:0];
    mvIf.mv_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!holdValid) mvIf.mv_valid = 1'b0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (mvIf.mv_done === 1'b1) begin
        lat   = k;
        errO  = mvIf.mv_err;
        captO = mvIf.mv_capt;
      end else if (mvIf.mv_ready !== 1'b0) begin
        readyOk = 1'b0;
      end
    end
    mvIf.mv_valid = 1'b0;
    @(posedge clk);
    #1;
    pulseOk = (mvIf.mv_done === 1'b0);
  endtask

  task automatic readSq(input int addr, output logic [3:0] data);
    int a = addr;
    sq_rd_addr = a[5:0];
    @(posedge clk);
    #1;
    data = sq_rd_data;
  endtask

  task automatic readBoard();
    for (int i = 0; i < 64; i++) readSq(i, dutBoard[i]);
  endtask

  task automatic pulseNewGame();
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    int         addrs [6] = '{0, 4, 12, 60, 63, 30};
    logic [3:0] want  [6] = '{4'h4, 4'h6, 4'h1, 4'hE, 4'hC, 4'h0};
    logic [3:0] got;
    reset         = 1'b1;
    new_game      = 1'b0;
    mvIf.mv_valid = 1'b0;
    mvIf.mv_src   = '0;
    mvIf.mv_dst   = '0;
    mvIf.mv_promo = '0;
    sq_rd_addr    = '0;
    #35;
    vectors++;
    if (mvIf.mv_ready !== 1'b1 || mvIf.mv_done !== 1'b0 || mvIf.mv_err !== 1'b0 ||
        mvIf.mv_capt !== 4'h0 || turn !== 1'b0 || mv_count !== '0 || sq_rd_data !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL reset outputs: ready=%b done=%b err=%b capt=%h turn=%b count=%0d rd=%h, want 1 0 0 0 0 0 0",
               mvIf.mv_ready, mvIf.mv_done, mvIf.mv_err, mvIf.mv_capt, turn, mv_count, sq_rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    for (int i = 0; i < 6; i++) begin
      readSq(addrs[i], got);
      vectors++;
      if (got !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL reset square %0d: got %h, want %h", addrs[i], got, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    move_t      seq [4] = '{'{52, 36, 0}, '{20, 28, 0}, '{12, 12, 0}, '{0, 1, 0}};
    bit         expErr, pulseOk, readyOk;
    logic [3:0] expCapt, capt;
    logic       err;
    int         lat;
    foreach (seq[i]) begin
      modelMove(seq[i].src, seq[i].dst, seq[i].promo, expErr, expCapt);
      applyStimulus(seq[i].src, seq[i].dst, seq[i].promo, 1'b0, lat, err, capt, pulseOk, readyOk);
      vectors++;
      if (lat !== (expErr ? 2 : 3) || err !== expErr || capt !== expCapt || !pulseOk || !readyOk) begin
        miscompares++;
        $display("[TB] FAIL error move %0d->%0d: lat=%0d err=%b capt=%h pulse=%b ready=%b, want lat=%0d err=%b capt=%h pulse=1 ready=1",
                 seq[i].src, seq[i].dst, lat, err, capt, pulseOk, readyOk, expErr ? 2 : 3, expErr, expCapt);
      end
      vectors++;
      if (turn !== refTurn || mv_count !== CNT_W'(refCount)) begin
        miscompares++;
        $display("[TB] FAIL error move %0d->%0d state: turn=%b count=%0d, want turn=%b count=%0d",
                 seq[i].src, seq[i].dst, turn, mv_count, refTurn, refCount);
      end
    end
    readBoard();
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (dutBoard[i] !== 4'(refBoard[i])) begin
        miscompares++;
        $display("[TB] FAIL error board sq %0d: got %h, want %h", i, dutBoard[i], 4'(refBoard[i]));
      end
    end
  endtask

  task automatic test_e2e4();
    bit         expErr, pulseOk, readyOk;
    logic [3:0] expCapt, capt, d28, d12;
    logic       err;
    int         lat;
    modelMove(12, 28, 0, expErr, expCapt);
    applyStimulus(12, 28, 0, 1'b0, lat, err, capt, pulseOk, readyOk);
    vectors++;
    if (lat !== 3 || err !== 1'b0 || capt !== 4'h0 || !pulseOk || !readyOk) begin
      miscompares++;
      $display("[TB] FAIL e2e4 response: lat=%0d err=%b capt=%h pulse=%b ready=%b, want lat=3 err=0 capt=0 pulse=1 ready=1",
               lat, err, capt, pulseOk, readyOk);
    end
    readSq(28, d28);
    readSq(12, d12);
    vectors++;
    if (d28 !== 4'h1 || d12 !== 4'h0 || turn !== 1'b1 || mv_count !== CNT_W'(1)) begin
      miscompares++;
      $display("[TB] FAIL e2e4 state: sq28=%h sq12=%h turn=%b count=%0d, want 1 0 1 1", d28, d12, turn, mv_count);
    end
  endtask

  task automatic test_capture();
    move_t      seq [4] = '{'{57, 42, 0}, '{5, 33, 0}, '{48, 40, 0}, '{33, 42, 0}};
    bit         expErr, pulseOk, readyOk;
    logic [3:0] expCapt, capt, dDst, dSrc;
    logic       err;
    int         lat;
    foreach (seq[i]) begin
      modelMove(seq[i].src, seq[i].dst, seq[i].promo, expErr, expCapt);
      applyStimulus(seq[i].src, seq[i].dst, seq[i].promo, 1'b0, lat, err, capt, pulseOk, readyOk);
      readSq(seq[i].dst, dDst);
      readSq(seq[i].src, dSrc);
      vectors++;
      if (lat !== (expErr ? 2 : 3) || err !== expErr || capt !== expCapt || !pulseOk || !readyOk) begin
        miscompares++;
        $display("[TB] FAIL capture move %0d->%0d: lat=%0d err=%b capt=%h pulse=%b ready=%b, want lat=%0d err=%b capt=%h pulse=1 ready=1",
                 seq[i].src, seq[i].dst, lat, err, capt, pulseOk, readyOk, expErr ? 2 : 3, expErr, expCapt);
      end
      vectors++;
      if (dDst !== 4'(refBoard[seq[i].dst]) || dSrc !== 4'(refBoard[seq[i].src]) ||
          turn !== refTurn || mv_count !== CNT_W'(refCount)) begin
        miscompares++;
        $display("[TB] FAIL capture state %0d->%0d: dst=%h src=%h turn=%b count=%0d, want %h %h %b %0d",
                 seq[i].src, seq[i].dst, dDst, dSrc, turn, mv_count,
                 4'(refBoard[seq[i].dst]), 4'(refBoard[seq[i].src]), refTurn, refCount);
      end
    end
    vectors++;
    if (capt !== 4'hA || dDst !== 4'h3) begin
      miscompares++;
      $display("[TB] FAIL capture knight: capt=%h sq42=%h, want capt=a sq42=3", capt, dDst);
    end
  endtask

  task automatic test_promotion();
    move_t      seq [6] = '{'{12, 60, 2}, '{48, 40, 0}, '{60, 45, 0}, '{40, 32, 0}, '{11, 60, 7}, '{49, 1, 3}};
    bit         expErr, pulseOk, readyOk;
    logic [3:0] expCapt, capt, dDst, dSrc;
    logic       err;
    int         lat;
    pulseNewGame();
    foreach (seq[i]) begin
      modelMove(seq[i].src, seq[i].dst, seq[i].promo, expErr, expCapt);
      applyStimulus(seq[i].src, seq[i].dst, seq[i].promo, 1'b0, lat, err, capt, pulseOk, readyOk);
      readSq(seq[i].dst, dDst);
      readSq(seq[i].src, dSrc);
      vectors++;
      if (lat !== (expErr ? 2 : 3) || err !== expErr || capt !== expCapt || !pulseOk || !readyOk) begin
        miscompares++;
        $display("[TB] FAIL promotion move %0d->%0d: lat=%0d err=%b capt=%h pulse=%b ready=%b, want lat=%0d err=%b capt=%h pulse=1 ready=1",
                 seq[i].src, seq[i].dst, lat, err, capt, pulseOk, readyOk, expErr ? 2 : 3, expErr, expCapt);
      end
      vectors++;
      if (dDst !== 4'(refBoard[seq[i].dst]) || dSrc !== 4'(refBoard[seq[i].src]) ||
          turn !== refTurn || mv_count !== CNT_W'(refCount)) begin
        miscompares++;
        $display("[TB] FAIL promotion state %0d->%0d promo %0d: dst=%h src=%h turn=%b count=%0d, want %h %h %b %0d",
                 seq[i].src, seq[i].dst, seq[i].promo, dDst, dSrc, turn, mv_count,
                 4'(refBoard[seq[i].dst]), 4'(refBoard[seq[i].src]), refTurn, refCount);
      end
    end
  endtask

  task automatic test_back_to_back();
    move_t      seq [2] = '{'{13, 21, 0}, '{50, 42, 0}};
    bit         expErr, pulseOk, readyOk, extraDone;
    logic [3:0] expCapt, capt;
    logic       err;
    int         lat;
    foreach (seq[i]) begin
      modelMove(seq[i].src, seq[i].dst, seq[i].promo, expErr, expCapt);
      applyStimulus(seq[i].src, seq[i].dst, seq[i].promo, 1'b1, lat, err, capt, pulseOk, readyOk);
      vectors++;
      if (lat !== (expErr ? 2 : 3) || err !== expErr || capt !== expCapt || !pulseOk || !readyOk) begin
        miscompares++;
        $display("[TB] FAIL held-valid move %0d->%0d: lat=%0d err=%b capt=%h pulse=%b ready=%b, want lat=%0d err=%b capt=%h pulse=1 ready=1",
                 seq[i].src, seq[i].dst, lat, err, capt, pulseOk, readyOk, expErr ? 2 : 3, expErr, expCapt);
      end
    end
    extraDone = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (mvIf.mv_done !== 1'b0 || mvIf.mv_ready !== 1'b1) extraDone = 1'b1;
    end
    vectors++;
    if (extraDone || turn !== refTurn || mv_count !== CNT_W'(refCount)) begin
      miscompares++;
      $display("[TB] FAIL held-valid single accept: extra=%b turn=%b count=%0d, want extra=0 turn=%b count=%0d",
               extraDone, turn, mv_count, refTurn, refCount);
    end
  endtask

  task automatic test_new_game_abort();
    bit   doneSeen = 1'b0;
    logic readyAfter;
    mvIf.mv_src   = 6'd14;
    mvIf.mv_dst   = 6'd22;
    mvIf.mv_promo = 3'd0;
    mvIf.mv_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    if (mvIf.mv_done !== 1'b0) doneSeen = 1'b1;
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game      = 1'b0;
    mvIf.mv_valid = 1'b0;
    readyAfter    = mvIf.mv_ready;
    modelReset();
    for (int k = 0; k < 6; k++) begin
      if (mvIf.mv_done !== 1'b0) doneSeen = 1'b1;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (doneSeen || readyAfter !== 1'b1 || turn !== 1'b0 || mv_count !== '0) begin
      miscompares++;
      $display("[TB] FAIL abort state: done=%b ready=%b turn=%b count=%0d, want done=0 ready=1 turn=0 count=0",
               doneSeen, readyAfter, turn, mv_count);
    end
    readBoard();
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (dutBoard[i] !== 4'(refBoard[i])) begin
        miscompares++;
        $display("[TB] FAIL abort board sq %0d: got %h, want %h", i, dutBoard[i], 4'(refBoard[i]));
      end
    end
  endtask

  task automatic test_random();
    bit         expErr, pulseOk, readyOk;
    logic [3:0] expCapt, capt;
    logic       err;
    int         lat, src, dst, promo, tries;
    for (int n = 0; n < 60; n++) begin
      src = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        tries = 0;
        while (tries < 200 && (refBoard[src] == 0 || (refBoard[src] >= 8) != refTurn)) begin
          src = $urandom_range(0, 63);
          tries++;
        end
      end
      dst   = $urandom_range(0, 63);
      promo = $urandom_range(0, 7);
      modelMove(src, dst, promo, expErr, expCapt);
      applyStimulus(src, dst, promo, 1'b0, lat, err, capt, pulseOk, readyOk);
      vectors++;
      if (lat !== (expErr ? 2 : 3) || err !== expErr || capt !== expCapt || !pulseOk || !readyOk) begin
        miscompares++;
        $display("[TB] FAIL random move %0d->%0d promo %0d: lat=%0d err=%b capt=%h pulse=%b ready=%b, want lat=%0d err=%b capt=%h pulse=1 ready=1",
                 src, dst, promo, lat, err, capt, pulseOk, readyOk, expErr ? 2 : 3, expErr, expCapt);
      end
      vectors++;
      if (turn !== refTurn || mv_count !== CNT_W'(refCount)) begin
        miscompares++;
        $display("[TB] FAIL random state after %0d->%0d: turn=%b count=%0d, want turn=%b count=%0d",
                 src, dst, turn, mv_count, refTurn, refCount);
      end
    end
    readBoard();
    for (int i = 0; i < 64; i++) begin
      vectors++;
      if (dutBoard[i] !== 4'(refBoard[i])) begin
        miscompares++;
        $display("[TB] FAIL random board sq %0d: got %h, want %h", i, dutBoard[i], 4'(refBoard[i]));
      end
    end
  endtask

  task automatic test_count_saturation();
    move_t      dance [4] = '{'{1, 16, 0}, '{57, 42, 0}, '{16, 1, 0}, '{42, 57, 0}};
    bit         expErr, pulseOk, readyOk, anyBad;
    logic [3:0] expCapt, capt;
    logic       err;
    int         lat;
    pulseNewGame();
    anyBad = 1'b0;
    for (int n = 0; n < MAX_CNT + 9; n++) begin
      modelMove(dance[n % 4].src, dance[n % 4].dst, 0, expErr, expCapt);
      applyStimulus(dance[n % 4].src, dance[n % 4].dst, 0, 1'b0, lat, err, capt, pulseOk, readyOk);
      if (lat !== 3 || err !== 1'b0) anyBad = 1'b1;
    end
    vectors++;
    if (anyBad || mv_count !== CNT_W'(MAX_CNT) || refCount != MAX_CNT || turn !== refTurn) begin
      miscompares++;
      $display("[TB] FAIL count saturation: bad=%b count=%0d turn=%b, want bad=0 count=%0d turn=%b",
               anyBad, mv_count, turn, MAX_CNT, refTurn);
    end
  endtask

  initial begin
    test_reset();
    test_errors();
    test_e2e4();
    test_capture();
    test_promotion();
    test_back_to_back();
    test_new_game_abort();
    test_random();
    test_count_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
